// File: rtl/obi2ahbm_split_adapter.sv
// OBI v1.5 to AHB-Lite master adapter for the CV32E40P data port. Byte-enable
// patterns that are not naturally aligned are issued as several aligned AHB pieces.
module obi2ahbm_split_adapter #(
    parameter int   DATA_W           = 32,
    parameter int   ADDR_W           = 32,
    parameter logic HPROT_BUFFERABLE = 1'b0,
    parameter logic HPROT_CACHEABLE  = 1'b0
) (
    input  logic                hclk_i,
    input  logic                hresetn_i,
    output logic [ADDR_W-1:0]   haddr_o,
    output logic [2:0]          hburst_o,
    output logic                hmastlock_o,
    output logic [3:0]          hprot_o,
    output logic [2:0]          hsize_o,
    output logic [1:0]          htrans_o,
    output logic [DATA_W-1:0]   hwdata_o,
    output logic                hwrite_o,
    input  logic [DATA_W-1:0]   hrdata_i,
    input  logic                hready_i,
    input  logic                hresp_i,
    input  logic                data_req_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    input  logic                pending_dbus_xfer_i,
    input  logic                priv_mode_i
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic {S_IDLE, S_DATA} state_t;

    state_t              state_q;
    logic [ADDR_W-1:LB]  addr_q;
    logic                we_q;
    logic [NB-1:0]       rem_q;
    logic [NB-1:0]       cur_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merge_q;
    logic [ADDR_W-1:0]   haddr_q;
    logic [2:0]          hsize_q;
    logic                hwrite_q;
    logic [DATA_W-1:0]   hwdata_q;
    logic [3:0]          prot_q;

    logic                gnt;
    logic                issue;
    logic                rvalid;
    logic                err;
    logic [NB-1:0]       be_eff;
    logic [NB-1:0]       src_mask;
    logic [ADDR_W-1:LB]  src_addr;
    logic                src_we;
    logic [NB-1:0]       pc_mask;
    logic [LB-1:0]       pc_lsb;
    logic [2:0]          pc_size;
    logic [DATA_W-1:0]   rdata;

    // Greedy split: lowest remaining byte, widest naturally aligned fully-enabled run.
    function automatic void split_piece(input  logic [NB-1:0] m,
                                        output logic [NB-1:0] pm,
                                        output logic [LB-1:0] p_o,
                                        output logic [2:0]    k_o);
        int unsigned p;
        logic        found;
        logic [NB-1:0] wm;
        p     = 0;
        found = 1'b0;
        pm    = '0;
        k_o   = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (!found && m[i]) begin
                p     = i;
                found = 1'b1;
            end
        end
        if (found) begin
            for (int unsigned k = 0; k <= LB; k++) begin
                wm = ({NB{1'b1}} >> (NB - (1 << k))) << p;
                if ((p % (1 << k)) == 0 && (p + (1 << k)) <= NB && (m & wm) == wm) begin
                    pm  = wm;
                    k_o = 3'(k);
                end
            end
        end
        p_o = p[LB-1:0];
    endfunction

    always_comb begin
        gnt      = 1'b0;
        issue    = 1'b0;
        rvalid   = 1'b0;
        err      = 1'b0;
        be_eff   = (data_be_i == '0) ? '1 : data_be_i;
        src_mask = be_eff;
        src_addr = data_addr_i[ADDR_W-1:LB];
        src_we   = data_we_i;
        case (state_q)
            S_IDLE: begin
                gnt   = data_req_i & hready_i & ~pending_dbus_xfer_i & hresetn_i;
                issue = gnt;
            end
            S_DATA: begin
                if (hready_i) begin
                    if (hresp_i) begin
                        rvalid = 1'b1;
                        err    = 1'b1;
                    end else if (rem_q != '0) begin
                        issue    = 1'b1;
                        src_mask = rem_q;
                        src_addr = addr_q;
                        src_we   = we_q;
                    end else begin
                        rvalid = 1'b1;
                        gnt    = data_req_i & ~pending_dbus_xfer_i & hresetn_i;
                        issue  = gnt;
                    end
                end
            end
            default: ;
        endcase
        split_piece(src_mask, pc_mask, pc_lsb, pc_size);
        rdata = merge_q;
        for (int unsigned i = 0; i < NB; i++) begin
            if (cur_q[i]) rdata[8*i +: 8] = hrdata_i[8*i +: 8];
        end
    end

    assign hburst_o      = 3'b000;
    assign hmastlock_o   = 1'b0;
    assign htrans_o      = issue ? 2'b10 : 2'b00;
    assign haddr_o       = issue ? {src_addr, pc_lsb} : haddr_q;
    assign hsize_o       = issue ? pc_size : hsize_q;
    assign hwrite_o      = issue ? src_we : hwrite_q;
    assign hprot_o       = gnt ? {HPROT_CACHEABLE, HPROT_BUFFERABLE, priv_mode_i, 1'b1} : prot_q;
    assign hwdata_o      = hwdata_q;
    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid;
    assign data_err_o    = err;
    assign data_rdata_o  = rdata;

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            rem_q    <= '0;
            cur_q    <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            haddr_q  <= '0;
            hsize_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            prot_q   <= {HPROT_CACHEABLE, HPROT_BUFFERABLE, 1'b1, 1'b1};
        end else begin
            if (issue) begin
                haddr_q  <= haddr_o;
                hsize_q  <= pc_size;
                hwrite_q <= src_we;
                hwdata_q <= gnt ? data_wdata_i : wdata_q;
                rem_q    <= src_mask & ~pc_mask;
                cur_q    <= pc_mask;
            end
            if (gnt) begin
                addr_q  <= data_addr_i[ADDR_W-1:LB];
                we_q    <= data_we_i;
                wdata_q <= data_wdata_i;
                prot_q  <= {HPROT_CACHEABLE, HPROT_BUFFERABLE, priv_mode_i, 1'b1};
                merge_q <= '0;
            end else if (state_q == S_DATA && hready_i && !hresp_i) begin
                merge_q <= rdata;
            end
            case (state_q)
                S_IDLE: if (gnt) state_q <= S_DATA;
                S_DATA: begin
                    if (hready_i) begin
                        if (hresp_i)            state_q <= S_IDLE;
                        else if (rem_q != '0)   state_q <= S_DATA;
                        else                    state_q <= gnt ? S_DATA : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obi2ahbm_split_adapter.sv
// Scoreboard bench: stimulus queues expected AHB address phases and OBI responses,
// a negedge monitor pops and compares them as the adapter presents them.
module tb_obi2ahbm_split_adapter;

    logic        hclk_i = 1'b0;
    logic        hresetn_i;
    logic [31:0] haddr_o;
    logic [2:0]  hburst_o;
    logic        hmastlock_o;
    logic [3:0]  hprot_o;
    logic [2:0]  hsize_o;
    logic [1:0]  htrans_o;
    logic [31:0] hwdata_o;
    logic        hwrite_o;
    logic [31:0] hrdata_i;
    logic        hready_i;
    logic        hresp_i;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        pending_dbus_xfer_i;
    logic        priv_mode_i;

    obi2ahbm_split_adapter #(.DATA_W(32), .ADDR_W(32)) dut (
        .hclk_i(hclk_i), .hresetn_i(hresetn_i), .haddr_o(haddr_o), .hburst_o(hburst_o),
        .hmastlock_o(hmastlock_o), .hprot_o(hprot_o), .hsize_o(hsize_o), .htrans_o(htrans_o),
        .hwdata_o(hwdata_o), .hwrite_o(hwrite_o), .hrdata_i(hrdata_i), .hready_i(hready_i),
        .hresp_i(hresp_i), .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o), .pending_dbus_xfer_i(pending_dbus_xfer_i),
        .priv_mode_i(priv_mode_i)
    );

    always #5 hclk_i = ~hclk_i;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [3:0]  prot;
        logic [31:0] wdata;
    } aexp_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        logic        err;
        logic        wr;
    } rexp_t;

    aexp_t aq[$];
    rexp_t rq[$];

    int checks = 0;
    int errors = 0;
    int chk_gnt = -1;
    int chk_trans = -1;
    int chk_rv = -1;
    bit chk_reset = 1'b0;
    bit finish_req = 1'b0;
    bit done = 1'b0;
    bit dp_wr = 1'b0;
    logic [31:0] dp_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge hclk_i) begin
        aexp_t a;
        rexp_t r;
        if (chk_gnt >= 0)   check("gnt", 32'(data_gnt_o), 32'(chk_gnt));
        if (chk_trans >= 0) check("htrans", 32'(htrans_o), 32'(chk_trans));
        if (chk_rv >= 0)    check("rvalid", 32'(data_rvalid_o), 32'(chk_rv));
        if (chk_reset) begin
            check("rst_htrans", 32'(htrans_o), 32'h0);
            check("rst_gnt", 32'(data_gnt_o), 32'h0);
            check("rst_rvalid", 32'(data_rvalid_o), 32'h0);
            check("rst_err", 32'(data_err_o), 32'h0);
            check("rst_haddr", haddr_o, 32'h0);
            check("rst_hsize", 32'(hsize_o), 32'h0);
            check("rst_hwrite", 32'(hwrite_o), 32'h0);
            check("rst_hwdata", hwdata_o, 32'h0);
            check("rst_hprot", 32'(hprot_o), 32'h3);
            check("rst_hburst", 32'(hburst_o), 32'h0);
        end
        if (!hresetn_i) dp_wr = 1'b0;
        if (dp_wr) begin
            check("hwdata", hwdata_o, dp_wdata);
            if (hready_i) dp_wr = 1'b0;
        end
        if (htrans_o == 2'b10 && hready_i) begin
            if (aq.size() == 0) begin
                check("unexpected_nonseq_addr", haddr_o, 32'hFFFF_FFFF);
            end else begin
                a = aq.pop_front();
                check("haddr", haddr_o, a.addr);
                check("hsize", 32'(hsize_o), 32'(a.size));
                check("hwrite", 32'(hwrite_o), 32'(a.wr));
                check("hprot", 32'(hprot_o), 32'(a.prot));
                if (a.wr) begin
                    dp_wr = 1'b1;
                    dp_wdata = a.wdata;
                end
            end
        end
        if (data_rvalid_o) begin
            if (rq.size() == 0) begin
                check("unexpected_rvalid", 32'(data_rvalid_o), 32'h0);
            end else begin
                r = rq.pop_front();
                check("err", 32'(data_err_o), 32'(r.err));
                if (!r.wr && !r.err) check("rdata", data_rdata_o & r.mask, r.data & r.mask);
            end
        end
        if (finish_req && !done) begin
            check("addr_queue_left", 32'(aq.size()), 32'h0);
            check("resp_queue_left", 32'(rq.size()), 32'h0);
            done = 1'b1;
        end
    end

    task automatic step();
        @(posedge hclk_i);
        #1;
        chk_gnt = -1;
        chk_trans = -1;
        chk_rv = -1;
        chk_reset = 1'b0;
        data_req_i = 1'b0;
        hready_i = 1'b1;
        hresp_i = 1'b0;
        pending_dbus_xfer_i = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                          input logic [3:0] prot, input logic [31:0] wdata);
        aexp_t a;
        a.addr = addr; a.size = size; a.wr = wr; a.prot = prot; a.wdata = wdata;
        aq.push_back(a);
    endtask

    task automatic push_r(input logic [31:0] data, input logic [31:0] mask,
                          input logic err, input logic wr);
        rexp_t r;
        r.data = data; r.mask = mask; r.err = err; r.wr = wr;
        rq.push_back(r);
    endtask

    task automatic req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
        data_req_i = 1'b1;
        data_we_i = we;
        data_be_i = be;
        data_addr_i = addr;
        data_wdata_i = wdata;
    endtask

    initial begin
        hresetn_i = 1'b0;
        hrdata_i = '0;
        hready_i = 1'b1;
        hresp_i = 1'b0;
        data_req_i = 1'b0;
        data_we_i = 1'b0;
        data_be_i = '0;
        data_addr_i = '0;
        data_wdata_i = '0;
        pending_dbus_xfer_i = 1'b0;
        priv_mode_i = 1'b1;

        step(); chk_reset = 1'b1;
        step(); chk_reset = 1'b1;
        step(); hresetn_i = 1'b1; chk_trans = 0; chk_gnt = 0;

        // full-word read, zero wait states
        step(); req(1'b0, 4'hF, 32'h100, 32'h0); chk_gnt = 1; chk_rv = 0;
        push_a(32'h100, 3'd2, 1'b0, 4'h3, 32'h0);
        push_r(32'hDEADBEEF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(); hrdata_i = 32'hDEADBEEF; chk_rv = 1; chk_gnt = 0;
        step(); chk_rv = 0; chk_trans = 0;

        // split write in user mode, wait state inside first piece, req held
        step(); priv_mode_i = 1'b0; req(1'b1, 4'b0110, 32'h204, 32'hCAFEF00D); chk_gnt = 1;
        push_a(32'h205, 3'd0, 1'b1, 4'h1, 32'hCAFEF00D);
        step(); priv_mode_i = 1'b1; req(1'b1, 4'b0110, 32'h204, 32'h12345678);
        hready_i = 1'b0; chk_gnt = 0; chk_trans = 0; chk_rv = 0;
        step(); req(1'b1, 4'b0110, 32'h204, 32'h12345678); chk_gnt = 0; chk_trans = 2; chk_rv = 0;
        push_a(32'h206, 3'd0, 1'b1, 4'h1, 32'hCAFEF00D);
        push_r(32'h0, 32'h0, 1'b0, 1'b1);
        step(); chk_rv = 1;
        step(); chk_rv = 0;

        // split read with merge: halfword at 0x0, byte at 0x3
        step(); req(1'b0, 4'b1011, 32'h0, 32'h0); chk_gnt = 1;
        push_a(32'h0, 3'd1, 1'b0, 4'h3, 32'h0);
        push_r(32'hAA003344, 32'hFF00FFFF, 1'b0, 1'b0);
        step(); hrdata_i = 32'h11223344; chk_rv = 0; chk_trans = 2;
        push_a(32'h3, 3'd0, 1'b0, 4'h3, 32'h0);
        step(); hrdata_i = 32'hAABBCCDD; chk_rv = 1;
        step(); chk_rv = 0;

        // back-to-back pipelined reads
        step(); req(1'b0, 4'hF, 32'h10, 32'h0); chk_gnt = 1;
        push_a(32'h10, 3'd2, 1'b0, 4'h3, 32'h0);
        push_r(32'h1000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(); req(1'b0, 4'hF, 32'h14, 32'h0); hrdata_i = 32'h1000_0010; chk_gnt = 1; chk_rv = 1;
        push_a(32'h14, 3'd2, 1'b0, 4'h3, 32'h0);
        push_r(32'h2000_0014, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(); req(1'b0, 4'hF, 32'h18, 32'h0); hrdata_i = 32'h2000_0014; chk_gnt = 1; chk_rv = 1;
        push_a(32'h18, 3'd2, 1'b0, 4'h3, 32'h0);
        push_r(32'h3000_0018, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(); hrdata_i = 32'h3000_0018; chk_rv = 1; chk_gnt = 0;
        step(); chk_rv = 0;

        // zero byte-enable treated as full word
        step(); req(1'b0, 4'h0, 32'h602, 32'h0); chk_gnt = 1;
        push_a(32'h600, 3'd2, 1'b0, 4'h3, 32'h0);
        push_r(32'h76543210, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(); hrdata_i = 32'h76543210; chk_rv = 1;
        step(); chk_rv = 0;

        // split write where the first piece gets ERROR
        step(); req(1'b1, 4'b0110, 32'h40, 32'h5A5A5A5A); chk_gnt = 1;
        push_a(32'h41, 3'd0, 1'b1, 4'h3, 32'h5A5A5A5A);
        step(); req(1'b1, 4'b0110, 32'h40, 32'h5A5A5A5A);
        hready_i = 1'b0; hresp_i = 1'b1; chk_trans = 0; chk_gnt = 0; chk_rv = 0;
        step(); req(1'b1, 4'b0110, 32'h40, 32'h5A5A5A5A);
        hresp_i = 1'b1; chk_trans = 0; chk_gnt = 0; chk_rv = 1;
        push_r(32'h0, 32'h0, 1'b1, 1'b1);
        step(); chk_trans = 0; chk_rv = 0;

        // pending transfer blocks grant, then reset mid data phase
        step(); pending_dbus_xfer_i = 1'b1; req(1'b0, 4'hF, 32'h500, 32'hA5A5A5A5);
        chk_gnt = 0; chk_trans = 0;
        step(); pending_dbus_xfer_i = 1'b1; req(1'b0, 4'hF, 32'h500, 32'hA5A5A5A5);
        chk_gnt = 0; chk_trans = 0;
        step(); req(1'b0, 4'hF, 32'h500, 32'hA5A5A5A5); chk_gnt = 1; chk_trans = 2;
        push_a(32'h500, 3'd2, 1'b0, 4'h3, 32'h0);
        step(); hready_i = 1'b0; chk_reset = 1'b1;
        #2 hresetn_i = 1'b0;
        step(); chk_reset = 1'b1;
        step(); hresetn_i = 1'b1; chk_rv = 0; chk_trans = 0;
        step();

        finish_req = 1'b1;
        for (int i = 0; i < 10 && !done; i++) step();
        if (!done) begin
            $display("FAIL monitor_timeout: got done=0 expected done=1");
            $fatal(1, "monitor did not complete");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi2ahbm_split_adapter.md
Name: obi2ahbm_split_adapter

Overview:
Parametrised OBI v1.5 to AHB-Lite master adapter for the CV32E40P data port, the next generation of the existing single-transfer adapter. It supports a 32- or 64-bit data bus and splits non-contiguous or misaligned byte-enable patterns into a sequence of naturally aligned AHB transfers. Read data from all pieces is merged, and each OBI request gets exactly one rvalid. The AHB two-cycle ERROR response is handled with abort of any remaining pieces.

Parameters:
DATA_W, 32, data bus width; legal values are 32 and 64. NB = DATA_W/8.
ADDR_W, 32, address width.
HPROT_BUFFERABLE, 1'b0, value driven on hprot_o[2].
HPROT_CACHEABLE, 1'b0, value driven on hprot_o[3].

Ports:
hclk_i  in  1  AHB clock
hresetn_i  in  1  reset, asynchronous, active-low
haddr_o  out  ADDR_W  AHB address
hburst_o  out  3  tied to 3'b000 (SINGLE)
hmastlock_o  out  1  tied to 0
hprot_o  out  4  {CACHEABLE, BUFFERABLE, priv, 1'b1}
hsize_o  out  3  log2 of piece size in bytes
htrans_o  out  2  IDLE (00) or NONSEQ (10) only
hwdata_o  out  DATA_W  write data
hwrite_o  out  1  direction
hrdata_i  in  DATA_W  read data
hready_i  in  1  transfer done
hresp_i  in  1  ERROR response
data_req_i  in  1  OBI request
data_gnt_o  out  1  OBI grant
data_rvalid_o  out  1  OBI response valid
data_we_i  in  1  write enable
data_be_i  in  NB  byte enables
data_addr_i  in  ADDR_W  byte address
data_wdata_i  in  DATA_W  write data
data_rdata_o  out  DATA_W  merged read data
data_err_o  out  1  error, qualified by rvalid
pending_dbus_xfer_i  in  1  blocks new grants
priv_mode_i  in  1  1 = machine mode, 0 = user mode

Behaviour:
- Reset (async): state = IDLE; htrans_o = 00; data_gnt_o = 0; data_rvalid_o = 0; data_err_o = 0. Registered haddr, hsize, hwrite, hwdata and merge buffer reset to 0. hprot register resets to {C, B, 1, 1}. Reset mid-transfer drops the request without any response.
- Piece decomposition (greedy, low byte first): p = lowest set bit of the remaining mask. Size = largest 2^k with p mod 2^k == 0, 2^k <= NB, and bits p..p+2^k-1 all set.
  - haddr = {addr[ADDR_W-1:log2 NB], p}; hsize = k.
  - A byte enable of all zeros is treated as all ones.
- State IDLE (no data phase in flight):
  - data_gnt_o = data_req_i & hready_i & !pending_dbus_xfer_i.
  - On grant, the first piece's address phase is driven combinationally in the same cycle (htrans_o = NONSEQ).
  - The following are latched: addr, we, be remainder, wdata, priv. Next state = DATA.
- State DATA (one piece in data phase; hwdata_o = latched wdata on all lanes):
  - hready_i=0, hresp_i=0: wait. htrans_o = IDLE; no grant.
  - hready_i=0, hresp_i=1 (ERROR cycle 1): htrans_o = IDLE; no grant.
  - hready_i=1, hresp_i=1 (ERROR cycle 2): data_rvalid_o = 1 and data_err_o = 1. Remaining pieces are discarded; no grant this cycle. Next state = IDLE.
  - hready_i=1, hresp_i=0, remainder != 0: the next piece's address phase is driven this cycle (NONSEQ); no rvalid; no grant; stay in DATA.
  - hready_i=1, hresp_i=0, remainder == 0: data_rvalid_o = 1 and data_err_o = 0. A new request may be granted and its address issued in the same cycle (pipelined); next state = DATA if granted, else IDLE.
- data_rdata_o: per byte lane, hrdata_i for lanes of the completing piece, otherwise the merge-buffer byte. Merge buffer is cleared at grant. Valid only with rvalid; for writes the value is don't-care.
- data_rvalid_o is asserted exactly once per grant and never in the grant cycle.
- hwdata_o is updated only when an address phase is accepted (hready_i=1 with NONSEQ).
- No grant while pieces remain; pending_dbus_xfer_i gates grants only, never in-flight pieces.

Test Plan:
- DATA_W=32, read, be=4'hF, addr 0x100, hrdata 0xDEADBEEF, zero wait states -> one NONSEQ, hsize=2, rvalid one cycle after gnt, rdata=0xDEADBEEF.
- DATA_W=32, write, be=4'b0110, addr 0x204 -> two NONSEQ: 0x205 hsize=0, then 0x206 hsize=0. hwdata held across both; a single rvalid after the second piece; no gnt in between.
- DATA_W=32, read, be=4'b1011, hrdata 0x11223344 then 0xAABBCCDD -> pieces at 0x0 (size 1) and 0x3 (size 0); rdata=0xAA??3344 with byte 2 don't-care.
- Back-to-back reads with req held and hready=1 -> gnt on consecutive cycles, address of read N+1 overlaps data of read N, one rvalid per read.
- Split write where piece 1 gets ERROR (hresp=1/hready=0, then hresp=1/hready=1) -> htrans=IDLE in both cycles, piece 2 never issued, rvalid=1 and err=1 once.
- pending_dbus_xfer_i=1 with req=1 -> gnt=0 and htrans=IDLE. Deassert it -> gnt in that cycle. Async reset asserted mid-DATA -> all outputs at reset values, no rvalid.
